csr_arbiter: RTL and testbench

Arbiter and sequencer for the CSR storage used by the execute stage. Two requesters share that single asynchronous-read, synchronous-write CSR array:
- the pipeline (EX-stage csrrw/csrrwi);
- a host/debug port (UART monitor).

Each requester uses a valid/ready handshake; read data comes back as a registered response one cycle after the grant. The pipeline has priority, bounded by a starvation counter and a host lock mode for atomic read-modify-write.

---
 rtl/csr_arbiter.sv | 114 +++++++++++
 tb/tb_csr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/csr_arbiter.sv
// Two-requester arbiter in front of a single async-read / sync-write CSR array.
// The pipeline has priority; a starvation counter and a host lock mode bound that priority.
module csr_arbiter #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned AWIDTH       = 12,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshake: a request is granted in the cycle where valid_i && ready_o;
    // ready_o is only ever high together with valid_i. While valid_i=1 and
    // ready_o=0 the requester keeps addr/we/wdata stable. The response
    // (rvalid_o, rdata_o) follows one cycle after the grant.
    input  logic              p_valid_i,
    output logic              p_ready_o,
    input  logic              p_we_i,
    input  logic [AWIDTH-1:0] p_addr_i,
    input  logic [DWIDTH-1:0] p_wdata_i,
    output logic              p_rvalid_o,
    output logic [DWIDTH-1:0] p_rdata_o,
    input  logic              h_valid_i,
    output logic              h_ready_o,
    input  logic              h_we_i,
    input  logic [AWIDTH-1:0] h_addr_i,
    input  logic [DWIDTH-1:0] h_wdata_i,
    output logic              h_rvalid_o,
    output logic [DWIDTH-1:0] h_rdata_o,
    input  logic              h_lock_i,
    output logic              csr_we_o,
    output logic [AWIDTH-1:0] csr_addr_o,
    output logic [DWIDTH-1:0] csr_d_o,
    input  logic [DWIDTH-1:0] csr_q_i,
    output logic              locked_o,
    output logic              dbg_state_o,
    output logic [3:0]        dbg_starve_cnt_o
);

    typedef enum logic {ARB = 1'b0, HOST_LOCK = 1'b1} state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              p_rvalid_q, h_rvalid_q;
    logic [DWIDTH-1:0] p_rdata_q, h_rdata_q;
    logic              force_host, p_grant, h_grant;

    // Grants are gated by rst_n so nothing reaches the array while reset is held.
    always_comb begin
        force_host = (state_q == ARB) && h_valid_i && (starve_q == LIMIT);
        p_grant    = rst_n && p_valid_i && (state_q == ARB) && !force_host;
        h_grant    = rst_n && h_valid_i &&
                     ((state_q == HOST_LOCK) || force_host || !p_valid_i);
    end

    always_comb begin
        csr_we_o   = 1'b0;
        csr_addr_o = '0;
        csr_d_o    = '0;
        if (p_grant) begin
            csr_we_o   = p_we_i;
            csr_addr_o = p_addr_i;
            csr_d_o    = p_wdata_i;
        end else if (h_grant) begin
            csr_we_o   = h_we_i;
            csr_addr_o = h_addr_i;
            csr_d_o    = h_wdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        if (h_grant) begin
            state_d = h_lock_i ? HOST_LOCK : ARB;
        end

        starve_d = starve_q;
        if (h_grant || !h_valid_i) begin
            starve_d = '0;
        end else if ((state_q == ARB) && p_grant && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            starve_q   <= '0;
            p_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            p_rdata_q  <= '0;
            h_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            p_rvalid_q <= p_grant;
            h_rvalid_q <= h_grant;
            // Capture the pre-write value so a write returns the old contents.
            if (p_grant) p_rdata_q <= csr_q_i;
            if (h_grant) h_rdata_q <= csr_q_i;
        end
    end

    assign p_ready_o        = p_grant;
    assign h_ready_o        = h_grant;
    assign p_rvalid_o       = p_rvalid_q;
    assign h_rvalid_o       = h_rvalid_q;
    assign p_rdata_o        = p_rdata_q;
    assign h_rdata_o        = h_rdata_q;
    assign locked_o         = (state_q == HOST_LOCK);
    assign dbg_state_o      = state_q;
    assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter: a vector table with hand-computed expectations
// plus hand-written sequences for reset-in-lock and idle behaviour.
module tb_csr_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p_valid = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic          h_valid = 1'b0, h_we = 1'b0, h_lock = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic          p_ready, p_rvalid, h_ready, h_rvalid, csr_we, locked, dbg_state;
  logic [DW-1:0] p_rdata, h_rdata, csr_d, csr_q;
  logic [AW-1:0] csr_addr;
  logic [3:0]    dbg_starve;

  int total = 0;
  int bad = 0;

  // clock / reset block and CSR array model
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
    end else if (csr_we) begin
      mem[csr_addr] <= csr_d;
    end
  end
  assign csr_q = mem[csr_addr];

  csr_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid_i(p_valid), .p_ready_o(p_ready), .p_we_i(p_we), .p_addr_i(p_addr),
    .p_wdata_i(p_wdata), .p_rvalid_o(p_rvalid), .p_rdata_o(p_rdata),
    .h_valid_i(h_valid), .h_ready_o(h_ready), .h_we_i(h_we), .h_addr_i(h_addr),
    .h_wdata_i(h_wdata), .h_rvalid_o(h_rvalid), .h_rdata_o(h_rdata), .h_lock_i(h_lock),
    .csr_we_o(csr_we), .csr_addr_o(csr_addr), .csr_d_o(csr_d), .csr_q_i(csr_q),
    .locked_o(locked), .dbg_state_o(dbg_state), .dbg_starve_cnt_o(dbg_starve)
  );

  typedef struct {
    logic          pv, pwe;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwd;
    logic          hv, hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwd;
    logic          hlock;
    logic          e_pr, e_hr, e_we;
    logic [AW-1:0] e_addr;
    logic          e_lk, e_prv;
    logic [DW-1:0] e_prd;
    logic          e_hrv;
    logic [DW-1:0] e_hrd;
    logic [3:0]    e_st;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_p(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid = v; p_we = we; p_addr = a; p_wdata = d;
  endtask

  task automatic drive_h(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic lk);
    h_valid = v; h_we = we; h_addr = a; h_wdata = d; h_lock = lk;
  endtask

  initial begin
    // pv pwe paddr pwd | hv hwe haddr hwd hlock | pr hr we addr lk prv prd hrv hrd st
    vecs[0]  = '{1,1,12'h51E,32'hDEADBEEF, 0,0,12'h000,0,0, 1,0,1,12'h51E,0, 0,0,          0,0,          0};
    vecs[1]  = '{0,0,12'h000,0,            1,0,12'h51E,0,0, 0,1,0,12'h51E,0, 1,0,          0,0,          0};
    vecs[2]  = '{0,0,12'h000,0,            0,0,12'h000,0,0, 0,0,0,12'h000,0, 0,0,          1,32'hDEADBEEF,0};
    vecs[3]  = '{1,1,12'h100,1,            1,0,12'h100,0,0, 1,0,1,12'h100,0, 0,0,          0,32'hDEADBEEF,0};
    vecs[4]  = '{1,1,12'h100,2,            1,0,12'h100,0,0, 1,0,1,12'h100,0, 1,0,          0,32'hDEADBEEF,1};
    vecs[5]  = '{1,1,12'h100,3,            1,0,12'h100,0,0, 1,0,1,12'h100,0, 1,1,          0,32'hDEADBEEF,2};
    vecs[6]  = '{1,1,12'h100,4,            1,0,12'h100,0,0, 1,0,1,12'h100,0, 1,2,          0,32'hDEADBEEF,3};
    vecs[7]  = '{1,1,12'h100,5,            1,0,12'h100,0,0, 0,1,0,12'h100,0, 1,3,          0,32'hDEADBEEF,4};
    vecs[8]  = '{1,1,12'h100,5,            0,0,12'h000,0,0, 1,0,1,12'h100,0, 0,3,          1,4,          0};
    vecs[9]  = '{0,0,12'h000,0,            0,0,12'h000,0,0, 0,0,0,12'h000,0, 1,4,          0,4,          0};
    vecs[10] = '{0,0,12'h000,0,            1,0,12'h51E,0,1, 0,1,0,12'h51E,0, 0,4,          0,4,          0};
    vecs[11] = '{1,0,12'h51E,0,            0,0,12'h000,0,0, 0,0,0,12'h000,1, 0,4,          1,32'hDEADBEEF,0};
    vecs[12] = '{1,0,12'h51E,0,            1,1,12'h51E,1,0, 0,1,1,12'h51E,1, 0,4,          0,32'hDEADBEEF,0};
    vecs[13] = '{1,0,12'h51E,0,            0,0,12'h000,0,0, 1,0,0,12'h51E,0, 0,4,          1,32'hDEADBEEF,0};
    vecs[14] = '{0,0,12'h000,0,            0,0,12'h000,0,0, 0,0,0,12'h000,0, 1,1,          0,32'hDEADBEEF,0};
    vecs[15] = '{1,1,12'h51F,32'hA,        1,1,12'h51F,32'hB,0, 1,0,1,12'h51F,0, 0,1,      0,32'hDEADBEEF,0};
    vecs[16] = '{0,0,12'h000,0,            1,1,12'h51F,32'hB,0, 0,1,1,12'h51F,0, 1,0,      0,32'hDEADBEEF,1};
    vecs[17] = '{0,0,12'h000,0,            1,0,12'h51F,0,0, 0,1,0,12'h51F,0, 0,0,          1,32'hA,      0};
    vecs[18] = '{0,0,12'h000,0,            0,0,12'h000,0,0, 0,0,0,12'h000,0, 0,0,          1,32'hB,      0};

    // reset: ready and csr_we forced low even with both requests active
    drive_p(1, 1, 12'h51E, 32'h1234);
    drive_h(1, 1, 12'h51E, 32'h5678, 1);
    repeat (3) @(negedge clk);
    chk("rst_p_ready", p_ready, 0);
    chk("rst_h_ready", h_ready, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_locked", locked, 0);
    chk("rst_p_rvalid", p_rvalid, 0);
    chk("rst_h_rvalid", h_rvalid, 0);
    chk("rst_starve", dbg_starve, 0);
    drive_p(0, 0, 0, 0);
    drive_h(0, 0, 0, 0, 0);
    mem_clr = 1'b0;
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      drive_p(vecs[i].pv, vecs[i].pwe, vecs[i].paddr, vecs[i].pwd);
      drive_h(vecs[i].hv, vecs[i].hwe, vecs[i].haddr, vecs[i].hwd, vecs[i].hlock);
      @(negedge clk);
      chk($sformatf("v%0d_p_ready", i), p_ready, vecs[i].e_pr);
      chk($sformatf("v%0d_h_ready", i), h_ready, vecs[i].e_hr);
      chk($sformatf("v%0d_csr_we", i), csr_we, vecs[i].e_we);
      chk($sformatf("v%0d_csr_addr", i), csr_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_locked", i), locked, vecs[i].e_lk);
      chk($sformatf("v%0d_p_rvalid", i), p_rvalid, vecs[i].e_prv);
      chk($sformatf("v%0d_p_rdata", i), p_rdata, vecs[i].e_prd);
      chk($sformatf("v%0d_h_rvalid", i), h_rvalid, vecs[i].e_hrv);
      chk($sformatf("v%0d_h_rdata", i), h_rdata, vecs[i].e_hrd);
      chk($sformatf("v%0d_starve", i), dbg_starve, vecs[i].e_st);
    end

    // reset asserted while locked with a host response pending
    @(posedge clk); #1;
    drive_p(0, 0, 0, 0);
    drive_h(1, 0, 12'h51E, 0, 1);
    @(negedge clk);
    chk("lk_enter_h_ready", h_ready, 1);
    @(posedge clk); #1;
    drive_p(1, 0, 12'h51E, 0);
    @(negedge clk);
    chk("lk_locked", locked, 1);
    chk("lk_h_ready", h_ready, 1);
    chk("lk_p_ready", p_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_p_ready", p_ready, 0);
    chk("arst_h_ready", h_ready, 0);
    chk("arst_csr_we", csr_we, 0);
    chk("arst_csr_addr", csr_addr, 0);
    chk("arst_csr_d", csr_d, 0);
    chk("arst_locked", locked, 0);
    chk("arst_p_rvalid", p_rvalid, 0);
    chk("arst_h_rvalid", h_rvalid, 0);
    chk("arst_p_rdata", p_rdata, 0);
    chk("arst_h_rdata", h_rdata, 0);
    @(posedge clk); #1;
    drive_h(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_locked", locked, 0);
    chk("post_rst_p_ready", p_ready, 1);
    chk("post_rst_h_rvalid", h_rvalid, 0);
    @(posedge clk); #1;
    drive_p(0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_p_rvalid", p_rvalid, 1);
    chk("post_rst_p_rdata", p_rdata, 32'h1);
    chk("post_rst_h_rvalid2", h_rvalid, 0);

    // idle: nothing written, counter stays clear, no responses
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("idle%0d_csr_we", c), csr_we, 0);
      chk($sformatf("idle%0d_starve", c), dbg_starve, 0);
      chk($sformatf("idle%0d_p_rvalid", c), p_rvalid, 0);
      chk($sformatf("idle%0d_h_rvalid", c), h_rvalid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
